// File: rtl/ward_alarm_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// ward_alarm_pkg
// Shared constants, the scheduler state enum and a small level helper for the
// ward alarm scheduler.
//   NUM_BEDS : number of beds served by one scheduler
//   LEVEL_W  : width of a severity code (0 = normal, 1..7 = severity)
//   BED_W    : width of a bed index
// ---------------------------------------------------------------------------
package ward_alarm_pkg;

  localparam int NUM_BEDS = 4;
  localparam int LEVEL_W  = 3;
  localparam int BED_W    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALERT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Larger of two unsigned severity codes.
  function automatic logic [LEVEL_W-1:0] lvl_max(input logic [LEVEL_W-1:0] a,
                                                 input logic [LEVEL_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ward_alarm_scheduler_if.sv
// ---------------------------------------------------------------------------
// ward_alarm_scheduler_if
// Bundle between the bed controllers / nurse station and the scheduler.
//   patientWarning : 4 x 3-bit warning codes, bed i at [3i+2:3i]
//   nurseAck       : acknowledge of the presented alert
//   alertValid     : an alert is being presented
//   alertBed       : bed of the presented alert (0 when no alert)
//   alertLevel     : severity of the presented alert (0 when no alert)
//   escalate       : presented alert is unacknowledged for too long
//   pendingMask    : bit i set while bed i holds a non-zero pending level
// master = stimulus side (bed controllers / nurse), slave = scheduler.
// ---------------------------------------------------------------------------
interface ward_alarm_scheduler_if;
  import ward_alarm_pkg::*;

  logic [NUM_BEDS*LEVEL_W-1:0] patientWarning;
  logic                        nurseAck;
  logic                        alertValid;
  logic [BED_W-1:0]            alertBed;
  logic [LEVEL_W-1:0]          alertLevel;
  logic                        escalate;
  logic [NUM_BEDS-1:0]         pendingMask;

  modport master (
    output patientWarning, nurseAck,
    input  alertValid, alertBed, alertLevel, escalate, pendingMask
  );

  modport slave (
    input  patientWarning, nurseAck,
    output alertValid, alertBed, alertLevel, escalate, pendingMask
  );

endinterface

// File: rtl/ward_alarm_scheduler_bed_select.sv
// ---------------------------------------------------------------------------
// ward_bed_select
// Combinational winner selection: the bed with the highest pending level;
// equal levels are resolved round-robin starting after the last served bed.
//   levels_i      : pending level per bed
//   last_served_i : bed served most recently
//   winner_o      : selected bed (meaningful only when any_o = 1)
//   any_o         : at least one bed has a non-zero pending level
// ---------------------------------------------------------------------------
module ward_bed_select
  import ward_alarm_pkg::*;
(
  input  logic [NUM_BEDS-1:0][LEVEL_W-1:0] levels_i,
  input  logic [BED_W-1:0]                 last_served_i,
  output logic [BED_W-1:0]                 winner_o,
  output logic                             any_o
);

  logic [BED_W-1:0]   idx_s;
  logic [BED_W-1:0]   best_idx_s;
  logic [LEVEL_W-1:0] best_lvl_s;

  // Scan beds in round-robin order; strict '>' keeps the earliest bed of a tie.
  always_comb begin
    idx_s      = last_served_i;
    best_idx_s = last_served_i;
    best_lvl_s = {LEVEL_W{1'b0}};
    for (int k = 32'sd0; k < NUM_BEDS; k++) begin
      idx_s = last_served_i + BED_W'(k + 32'sd1);
      if (levels_i[idx_s] > best_lvl_s) begin
        best_lvl_s = levels_i[idx_s];
        best_idx_s = idx_s;
      end else begin
        best_lvl_s = best_lvl_s;
      end
    end
  end

  assign winner_o = best_idx_s;
  assign any_o    = (best_lvl_s != {LEVEL_W{1'b0}});

endmodule

// File: rtl/ward_alarm_scheduler.sv
// ---------------------------------------------------------------------------
// ward_alarm_scheduler
// Collects per-bed warnings into sticky pending levels, presents one alert at
// a time to the nurse station, escalates an alert left unacknowledged for
// ACK_TIMEOUT cycles, and idles HOLDOFF cycles after each acknowledge.
//   clock : system clock, rising edge
//   reset : asynchronous, active-high; clears all state and outputs
//   bus   : ward_alarm_scheduler_if.slave (warnings/ack in, alert out)
// ---------------------------------------------------------------------------
module ward_alarm_scheduler
  import ward_alarm_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int HOLDOFF     = 2
)
(
  input logic                   clock,
  input logic                   reset,
  ward_alarm_scheduler_if.slave bus
);

  localparam int TMR_W  = $clog2(ACK_TIMEOUT) + 1;
  localparam int HOLD_W = $clog2(HOLDOFF + 1) + 1;

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ALERT = ALERT;
  localparam logic [1:0] S_HOLD  = HOLD;

  logic [1:0]                       state_q, state_d;
  logic [NUM_BEDS-1:0][LEVEL_W-1:0] pending_q, pending_d;
  logic [NUM_BEDS-1:0][LEVEL_W-1:0] warn_s;
  logic [BED_W-1:0]                 last_q, last_d;
  logic [TMR_W-1:0]                 timer_q, timer_d;
  logic [HOLD_W-1:0]                hold_q, hold_d;
  logic                             valid_q, valid_d;
  logic [BED_W-1:0]                 bed_q, bed_d;
  logic [LEVEL_W-1:0]               level_q, level_d;
  logic                             esc_q, esc_d;
  logic [NUM_BEDS-1:0]              mask_q, mask_d;
  logic [BED_W-1:0]                 win_s;
  logic                             any_s;

  // Packed 4x3 view lines up bed i with bits [3i+2:3i].
  assign warn_s = bus.patientWarning;

  ward_bed_select u_sel (
    .levels_i      (pending_q),
    .last_served_i (last_q),
    .winner_o      (win_s),
    .any_o         (any_s)
  );

  // Next-state logic: pending capture, FSM, ack timer and hold counter.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    timer_d = timer_q;
    hold_d  = hold_q;
    valid_d = valid_q;
    bed_d   = bed_q;
    level_d = level_q;
    esc_d   = esc_q;
    for (int i = 32'sd0; i < NUM_BEDS; i++) begin
      pending_d[i] = lvl_max(pending_q[i], warn_s[i]);
    end

    case (state_q)
      S_IDLE: begin
        if (any_s) begin
          state_d = S_ALERT;
          valid_d = 1'b1;
          bed_d   = win_s;
          level_d = pending_q[win_s];
          timer_d = {TMR_W{1'b0}};
          esc_d   = 1'b0;
        end else begin
          valid_d = 1'b0;
          bed_d   = {BED_W{1'b0}};
          level_d = {LEVEL_W{1'b0}};
        end
      end

      S_ALERT: begin
        if (bus.nurseAck) begin
          // A fresh warning on the served bed at the ack edge survives.
          pending_d[bed_q] = warn_s[bed_q];
          last_d  = bed_q;
          timer_d = {TMR_W{1'b0}};
          hold_d  = {HOLD_W{1'b0}};
          esc_d   = 1'b0;
          valid_d = 1'b0;
          bed_d   = {BED_W{1'b0}};
          level_d = {LEVEL_W{1'b0}};
          state_d = (HOLDOFF == 32'sd0) ? S_IDLE : S_HOLD;
        end else begin
          // Saturate so a long-ignored alert keeps escalate high forever.
          if (int'(timer_q) < ACK_TIMEOUT) begin
            timer_d = timer_q + TMR_W'(1'b1);
          end else begin
            timer_d = timer_q;
          end
          if (int'(timer_q) + 32'sd1 >= ACK_TIMEOUT) begin
            esc_d = 1'b1;
          end else begin
            esc_d = esc_q;
          end
        end
      end

      S_HOLD: begin
        if (int'(hold_q) + 32'sd1 >= HOLDOFF) begin
          state_d = S_IDLE;
          hold_d  = {HOLD_W{1'b0}};
        end else begin
          hold_d  = hold_q + HOLD_W'(1'b1);
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        bed_d   = {BED_W{1'b0}};
        level_d = {LEVEL_W{1'b0}};
        esc_d   = 1'b0;
        timer_d = {TMR_W{1'b0}};
        hold_d  = {HOLD_W{1'b0}};
      end
    endcase

    for (int i = 32'sd0; i < NUM_BEDS; i++) begin
      mask_d[i] = |pending_d[i];
    end
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      last_q    <= BED_W'(NUM_BEDS - 32'sd1);
      timer_q   <= {TMR_W{1'b0}};
      hold_q    <= {HOLD_W{1'b0}};
      valid_q   <= 1'b0;
      bed_q     <= {BED_W{1'b0}};
      level_q   <= {LEVEL_W{1'b0}};
      esc_q     <= 1'b0;
      mask_q    <= {NUM_BEDS{1'b0}};
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      last_q    <= last_d;
      timer_q   <= timer_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      bed_q     <= bed_d;
      level_q   <= level_d;
      esc_q     <= esc_d;
      mask_q    <= mask_d;
    end
  end

  assign bus.alertValid  = valid_q;
  assign bus.alertBed    = bed_q;
  assign bus.alertLevel  = level_q;
  assign bus.escalate    = esc_q;
  assign bus.pendingMask = mask_q;

endmodule

// File: tb/tb_ward_alarm_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ward_alarm_scheduler
// Directed scenarios with literal expectations followed by randomized
// warnings/acks/resets, all compared every cycle against a behavioural model.
// ---------------------------------------------------------------------------
module tb_ward_alarm_scheduler;

  localparam int ACK_TO = 16;
  localparam int HOLD_N = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  ward_alarm_scheduler_if bus_if();

  ward_alarm_scheduler #(.ACK_TIMEOUT(ACK_TO), .HOLDOFF(HOLD_N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: sticky levels, "presenting" flag, age of the alert,
  // remaining quiet cycles after an acknowledge.
  int pend[4];
  int nxt[4];
  int last_srv;
  bit presenting;
  int hold_left;
  int age;
  int m_bed;
  int m_lvl;
  bit m_esc;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) pend[i] = 0;
    last_srv = 3; presenting = 0; hold_left = 0; age = 0;
    m_bed = 0; m_lvl = 0; m_esc = 0;
  endtask

  task automatic model_step(input logic [11:0] w, input logic ack);
    int wl[4];
    int best_l, best_b, idx;
    for (int i = 0; i < 4; i++) begin
      wl[i]  = int'(w[3*i +: 3]);
      nxt[i] = (wl[i] > pend[i]) ? wl[i] : pend[i];
    end
    if (presenting) begin
      if (ack) begin
        nxt[m_bed] = wl[m_bed];
        last_srv   = m_bed;
        presenting = 0;
        hold_left  = HOLD_N;
        age = 0; m_esc = 0;
      end else begin
        age++;
        m_esc = (age >= ACK_TO);
      end
    end else if (hold_left > 0) begin
      hold_left--;
    end else begin
      best_l = 0; best_b = -1;
      for (int k = 1; k <= 4; k++) begin
        idx = (last_srv + k) % 4;
        if (pend[idx] > best_l) begin best_l = pend[idx]; best_b = idx; end
      end
      if (best_b >= 0) begin
        presenting = 1; m_bed = best_b; m_lvl = best_l; age = 0; m_esc = 0;
      end
    end
    for (int i = 0; i < 4; i++) pend[i] = nxt[i];
  endtask

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clock);
      chk("valid", int'(bus_if.alertValid), int'(presenting));
      chk("bed",   int'(bus_if.alertBed),   presenting ? m_bed : 0);
      chk("level", int'(bus_if.alertLevel), presenting ? m_lvl : 0);
      chk("esc",   int'(bus_if.escalate),   int'(m_esc));
      for (int i = 0; i < 4; i++)
        chk("mask", int'(bus_if.pendingMask[i]), (pend[i] != 0) ? 1 : 0);
    end
  end

  task automatic tick(input logic [11:0] w, input logic a);
    bus_if.patientWarning = w;
    bus_if.nurseAck       = a;
    @(posedge clock);
    if (reset) model_reset();
    else model_step(w, a);
    @(negedge clock);
  endtask

  task automatic expect_out(input string tag, input int v, input int b,
                            input int l, input int e, input int m);
    chk({tag, "_valid"}, int'(bus_if.alertValid), v);
    chk({tag, "_bed"},   int'(bus_if.alertBed), b);
    chk({tag, "_level"}, int'(bus_if.alertLevel), l);
    chk({tag, "_esc"},   int'(bus_if.escalate), e);
    chk({tag, "_mask"},  int'(bus_if.pendingMask), m);
  endtask

  // Reset pulse between clock edges; outputs must clear before any edge.
  task automatic mid_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    expect_out("midrst", 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic [11:0] w;
    logic a;
    model_reset();
    bus_if.patientWarning = 12'h000;
    bus_if.nurseAck       = 1'b0;
    repeat (2) @(negedge clock);
    expect_out("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Single one-cycle warning, bed2 = 5.
    tick(12'h140, 1'b0); expect_out("w1_cap", 0, 0, 0, 0, 4'b0100);
    tick(12'h000, 1'b0); expect_out("w1_alert", 1, 2, 5, 0, 4'b0100);
    tick(12'h000, 1'b1); expect_out("w1_ack", 0, 0, 0, 0, 0);
    tick(12'h000, 1'b1); expect_out("w1_hold1", 0, 0, 0, 0, 0);
    tick(12'h000, 1'b0); expect_out("w1_hold2", 0, 0, 0, 0, 0);

    // bed1 = 3 and bed3 = 6 together: bed3 first, then bed1.
    tick(12'hC18, 1'b0); expect_out("two_cap", 0, 0, 0, 0, 4'b1010);
    tick(12'h000, 1'b0); expect_out("two_a", 1, 3, 6, 0, 4'b1010);
    tick(12'h000, 1'b1);
    tick(12'h000, 1'b0);
    tick(12'h000, 1'b0); expect_out("two_gap", 0, 0, 0, 0, 4'b0010);
    tick(12'h000, 1'b0); expect_out("two_b", 1, 1, 3, 0, 4'b0010);
    tick(12'h000, 1'b1);
    repeat (2) tick(12'h000, 1'b0);

    // Make bed0 the last served, then tie bed0/bed2 at level 4.
    tick(12'h001, 1'b0);
    tick(12'h000, 1'b0); expect_out("rr_pre", 1, 0, 1, 0, 4'b0001);
    tick(12'h000, 1'b1);
    repeat (2) tick(12'h000, 1'b0);
    tick(12'h104, 1'b0);
    tick(12'h000, 1'b0); expect_out("rr_a", 1, 2, 4, 0, 4'b0101);
    tick(12'h000, 1'b1);
    repeat (3) tick(12'h000, 1'b0);
    expect_out("rr_b", 1, 0, 4, 0, 4'b0001);
    tick(12'h000, 1'b1);
    repeat (2) tick(12'h000, 1'b0);

    // Escalation after 16 unacknowledged cycles.
    tick(12'h010, 1'b0);
    tick(12'h000, 1'b0);
    repeat (15) tick(12'h000, 1'b0);
    expect_out("esc15", 1, 1, 2, 0, 4'b0010);
    tick(12'h000, 1'b0); expect_out("esc16", 1, 1, 2, 1, 4'b0010);
    repeat (20) tick(12'h000, 1'b0);
    expect_out("esc_sat", 1, 1, 2, 1, 4'b0010);
    tick(12'h000, 1'b1); expect_out("esc_ack", 0, 0, 0, 0, 0);
    repeat (2) tick(12'h000, 1'b0);

    // Ack on bed1 while bed1 raises 7 on the same edge.
    tick(12'h008, 1'b0);
    tick(12'h000, 1'b0);
    tick(12'h038, 1'b1); expect_out("newev_ack", 0, 0, 0, 0, 4'b0010);
    repeat (3) tick(12'h000, 1'b0);
    expect_out("newev_alert", 1, 1, 7, 0, 4'b0010);
    tick(12'h000, 1'b1);
    repeat (2) tick(12'h000, 1'b0);

    // Reset between edges during an escalated alert.
    tick(12'h600, 1'b0);
    repeat (18) tick(12'h000, 1'b0);
    expect_out("prerst", 1, 3, 3, 1, 4'b1000);
    mid_reset();
    repeat (3) tick(12'h000, 1'b0);
    expect_out("postrst", 0, 0, 0, 0, 0);

    // Randomized traffic; some phases starve acks to reach escalation.
    for (int n = 0; n < 4000; n++) begin
      w = 12'h000;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 9) == 0) w[3*i +: 3] = 3'($urandom_range(1, 7));
      if ((n % 700) < 120) a = ($urandom_range(0, 29) == 0);
      else a = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 799) == 0) mid_reset();
      tick(w, a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
